// File: rtl/sprite_arb_pkg.sv
// Shared types and defaults for the sprite ROM arbiter and its round-robin picker.
package sprite_arb_pkg;

  localparam int unsigned DefAddrW = 10;
  localparam int unsigned DefDataW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StLocked
  } arb_state_t;

  // Binary ID width for n requesters, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: searches upward from last_gnt+1 with wrap-around and
// returns the winner as one-hot and as a binary ID.
module rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] last_gnt,
  output logic [N-1:0]   gnt,
  output logic [IdW-1:0] id
);

  function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned k);
    return (base + k >= N) ? base + k - N : base + k;
  endfunction

  logic           found;
  logic [IdW-1:0] idx;

  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IdW'(wrap_idx(int'(last_gnt), k));
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        id       = idx;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM among NUM_REQ drawers, with ID-tagged
// return data. Define SPRITE_ARB_LOCK_EN to add the per-requester lock input for row bursts.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                        vga_clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
`ifdef SPRITE_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]          lock,
`endif
  output logic [NUM_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]           rom_address,
  input  logic [DATA_W-1:0]           rom_q,
  output logic                        rd_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rd_id,
  output logic [DATA_W-1:0]           rd_data
);

  localparam int unsigned IdW = id_width(NUM_REQ);

  arb_state_t           state_q;
  logic [IdW-1:0]       last_gnt_q;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IdW-1:0]       pick_id;
  logic [NUM_REQ-1:0]   gnt_c;
  logic [IdW-1:0]       gnt_id;
  logic                 any_req;
  logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
  logic [ROM_LAT:0]     tag_valid_q;
  logic [IdW-1:0]       tag_id_q [ROM_LAT+1];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
  end

  assign any_req = |req;

  rr_pick #(
    .N   (NUM_REQ),
    .IdW (IdW)
  ) u_pick (
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt      (pick_gnt),
    .id       (pick_id)
  );

`ifdef SPRITE_ARB_LOCK_EN
  // While locked, last_gnt_q already holds the locked requester's ID.
  logic lock_hold;
  assign lock_hold = (state_q == StLocked) && req[last_gnt_q] && lock[last_gnt_q];

  always_comb begin
    gnt_c  = pick_gnt;
    gnt_id = pick_id;
    if (lock_hold) begin
      gnt_c             = '0;
      gnt_c[last_gnt_q] = 1'b1;
      gnt_id            = last_gnt_q;
    end
  end
`else
  assign gnt_c  = pick_gnt;
  assign gnt_id = pick_id;
`endif

  // Grant is suppressed while reset is held so no request is accepted then.
  assign gnt = reset ? '0 : gnt_c;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      last_gnt_q  <= IdW'(NUM_REQ - 1);
      rom_address <= '0;
      tag_valid_q <= '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        tag_id_q[i] <= '0;
      end
      rd_valid    <= 1'b0;
      rd_id       <= '0;
      rd_data     <= '0;
    end else begin
      if (!any_req) begin
        state_q <= StIdle;
      end
`ifdef SPRITE_ARB_LOCK_EN
      else if (lock[gnt_id]) begin
        state_q <= StLocked;
      end
`endif
      else begin
        state_q <= StArb;
      end

      if (any_req) begin
        rom_address <= addr_arr[gnt_id];
        last_gnt_q  <= gnt_id;
      end

      // Tag pipeline lines the winner ID up with the ROM word one stage past rom_q.
      tag_valid_q[0] <= any_req;
      tag_id_q[0]    <= gnt_id;
      for (int i = 1; i <= ROM_LAT; i++) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
        tag_id_q[i]    <= tag_id_q[i-1];
      end

      rd_valid <= tag_valid_q[ROM_LAT];
      rd_id    <= tag_id_q[ROM_LAT];
      rd_data  <= rom_q;
    end
  end

  gnt_onehot_a: assert property (@(posedge vga_clk) $onehot0(gnt));
`ifndef SPRITE_ARB_LOCK_EN
  no_lock_state_a: assert property (@(posedge vga_clk) state_q != StLocked);
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed table-driven bench for sprite_rom_arbiter with a one-cycle ROM model.
module tb_sprite_rom_arbiter;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [39:0] req_addr;
  logic [3:0]  gnt;
  logic [9:0]  rom_address;
  logic [3:0]  rom_q = 4'h0;
  logic        rd_valid;
  logic [1:0]  rd_id;
  logic [3:0]  rd_data;
`ifdef SPRITE_ARB_LOCK_EN
  logic [3:0]  lock;
`endif

  int checks = 0;
  int errors = 0;

  always #20 vga_clk = ~vga_clk;

  sprite_rom_arbiter dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .req         (req),
    .req_addr    (req_addr),
`ifdef SPRITE_ARB_LOCK_EN
    .lock        (lock),
`endif
    .gnt         (gnt),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .rd_valid    (rd_valid),
    .rd_id       (rd_id),
    .rd_data     (rd_data)
  );

  function automatic logic [3:0] rom_fn(input logic [9:0] a);
    return a[3:0] ^ a[7:4] ^ {2'b00, a[9:8]};
  endfunction

  // Synchronous ROM, one-cycle latency.
  always_ff @(posedge vga_clk) rom_q <= rom_fn(rom_address);

  function automatic int oh2id(input logic [3:0] g);
    int r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [39:0] addrs;
    logic [3:0]  exp_gnt;
  } vec_t;

  localparam int NV = 15;
  vec_t        vecs [NV];
  logic        hv    [NV];
  int          hid   [NV];
  logic [9:0]  haddr [NV];
  logic [9:0]  cur_addr;

  initial begin
    // Expected grants hand-derived from last_gnt = 3 after reset.
    vecs[0]  = '{req: 4'b0001, addrs: '0, exp_gnt: 4'b0001};
    vecs[1]  = '{req: 4'b1111, addrs: '0, exp_gnt: 4'b0010};
    vecs[2]  = '{req: 4'b1111, addrs: '0, exp_gnt: 4'b0100};
    vecs[3]  = '{req: 4'b1111, addrs: '0, exp_gnt: 4'b1000};
    vecs[4]  = '{req: 4'b1111, addrs: '0, exp_gnt: 4'b0001};
    vecs[5]  = '{req: 4'b1111, addrs: '0, exp_gnt: 4'b0010};
    vecs[6]  = '{req: 4'b1111, addrs: '0, exp_gnt: 4'b0100};
    vecs[7]  = '{req: 4'b0011, addrs: '0, exp_gnt: 4'b0001};
    vecs[8]  = '{req: 4'b0011, addrs: '0, exp_gnt: 4'b0010};
    vecs[9]  = '{req: 4'b0000, addrs: '0, exp_gnt: 4'b0000};
    vecs[10] = '{req: 4'b1010, addrs: '0, exp_gnt: 4'b1000};
    vecs[11] = '{req: 4'b1010, addrs: '0, exp_gnt: 4'b0010};
    vecs[12] = '{req: 4'b0101, addrs: '0, exp_gnt: 4'b0100};
    vecs[13] = '{req: 4'b1001, addrs: '0, exp_gnt: 4'b1000};
    vecs[14] = '{req: 4'b0000, addrs: '0, exp_gnt: 4'b0000};
    for (int i = 0; i < NV; i++) begin
      for (int j = 0; j < 4; j++) begin
        vecs[i].addrs[j*10 +: 10] = 10'((i * 53 + j * 211 + 7) & 32'h3ff);
      end
    end
    vecs[0].addrs[9:0] = 10'h155;

    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
`ifdef SPRITE_ARB_LOCK_EN
    lock     = '0;
`endif
    step();
    step();
    // Requests during reset must not be granted.
    req = 4'b1111;
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_rom_address", 32'(rom_address), 32'h0);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_rd_id", 32'(rd_id), 32'h0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    reset    = 1'b0;
    cur_addr = '0;

    for (int i = 0; i < NV + 3; i++) begin
      if (i < NV) begin
        req      = vecs[i].req;
        req_addr = vecs[i].addrs;
      end else begin
        req = '0;
      end
      #1;
      if (i < NV) begin
        chk("tbl_gnt", 32'(gnt), 32'(vecs[i].exp_gnt));
        hv[i]    = (vecs[i].exp_gnt != 4'b0000);
        hid[i]   = oh2id(vecs[i].exp_gnt);
        haddr[i] = vecs[i].addrs[hid[i]*10 +: 10];
      end
      chk("tbl_rom_address", 32'(rom_address), 32'(cur_addr));
      if (i >= 3) begin
        chk("tbl_rd_valid", 32'(rd_valid), 32'(hv[i-3]));
        if (hv[i-3]) begin
          chk("tbl_rd_id", 32'(rd_id), 32'(hid[i-3]));
          chk("tbl_rd_data", 32'(rd_data), 32'(rom_fn(haddr[i-3])));
        end
      end else begin
        chk("tbl_rd_valid_fill", 32'(rd_valid), 32'h0);
      end
      if (i < NV && hv[i]) cur_addr = haddr[i];
      step();
    end

    // Idle: nothing granted, nothing returned, address held.
    for (int i = 0; i < 5; i++) begin
      req = '0;
      #1;
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_rd_valid", 32'(rd_valid), 32'h0);
      chk("idle_rom_address", 32'(rom_address), 32'(cur_addr));
      step();
    end

    // Reset with two reads in flight.
    req = 4'b0001;
    req_addr[9:0] = 10'h2a5;
    #1;
    chk("rst_seq_gnt0", 32'(gnt), 32'h1);
    step();
    req = 4'b0010;
    req_addr[19:10] = 10'h0f3;
    #1;
    chk("rst_seq_gnt1", 32'(gnt), 32'h2);
    step();
    reset = 1'b1;
    req   = 4'b1111;
    #1;
    chk("rst_seq_gnt_held", 32'(gnt), 32'h0);
    step();
    chk("rst_seq_rom_address", 32'(rom_address), 32'h0);
    chk("rst_seq_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_seq_rd_id", 32'(rd_id), 32'h0);
    chk("rst_seq_rd_data", 32'(rd_data), 32'h0);
    reset = 1'b0;
    req   = 4'b0110;
    req_addr[19:10] = 10'h3c1;
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'h2);
    step();
    req = '0;
    #1;
    chk("post_rst_rd_valid_a", 32'(rd_valid), 32'h0);
    chk("post_rst_rom_address", 32'(rom_address), 32'h3c1);
    step();
    chk("post_rst_rd_valid_b", 32'(rd_valid), 32'h0);
    step();
    chk("post_rst_rd_valid_c", 32'(rd_valid), 32'h1);
    chk("post_rst_rd_id", 32'(rd_id), 32'h1);
    chk("post_rst_rd_data", 32'(rd_data), 32'(rom_fn(10'h3c1)));
    step();
    chk("post_rst_rd_valid_d", 32'(rd_valid), 32'h0);

`ifdef SPRITE_ARB_LOCK_EN
    // last_gnt is 1 here; a grant to 0 first puts requester 1 next in line.
    req  = 4'b0001;
    lock = 4'b0000;
    #1;
    chk("lock_pre_gnt", 32'(gnt), 32'h1);
    step();
    for (int i = 0; i < 4; i++) begin
      req  = 4'b1111;
      lock = 4'b0010;
      #1;
      chk("lock_hold_gnt", 32'(gnt), 32'h2);
      step();
    end
    lock = 4'b0000;
    #1;
    chk("lock_release_gnt", 32'(gnt), 32'h4);
    step();
    req = '0;
    for (int i = 0; i < 4; i++) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
